// File: rtl/mips_pkg.sv
// mips_pkg
//   Definitions shared by the MIPS control decoder and the hazard controller:
//   opcode constants, the register-index width and the hazard FSM state type.
//   reads_rt() tells whether an opcode uses its rt field as a source operand.
package mips_pkg;

  localparam int REG_W = 5;
  localparam int OP_W  = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } hazard_state_t;

  // R-type, sw and beq read rt; every other opcode (lw, addi, ...) writes it
  // or ignores it, so an rt match there is not a real dependency.
  function automatic logic reads_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Combinational load-use compare between the lw in EX and the instruction
//   in ID.
//   Inputs : idExMemRead, idExRt  - lw in EX and its destination register
//            ifIdRs, ifIdRt       - source registers of the instruction in ID
//            ifIdOpCode           - opcode of the instruction in ID
//   Output : hazard               - the ID instruction needs the lw result now
module load_use_detect
  import mips_pkg::*;
(
  input  logic             idExMemRead,
  input  logic [REG_W-1:0] idExRt,
  input  logic [REG_W-1:0] ifIdRs,
  input  logic [REG_W-1:0] ifIdRt,
  input  logic [OP_W-1:0]  ifIdOpCode,
  output logic             hazard
);

  logic rs_match;
  logic rt_match;

  // $zero is never a real dependency.
  assign rs_match = (idExRt == ifIdRs);
  assign rt_match = (idExRt == ifIdRt) && reads_rt(ifIdOpCode);
  assign hazard   = idExMemRead && (idExRt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard/stall controller for the five-stage MIPS core. Resolves
//   data-memory waits (freeze, with timeout), taken-beq flushes and load-use
//   stalls, in that priority order. Outputs are Mealy: combinational from the
//   FSM state and the current inputs.
//   Parameters: MEM_TIMEOUT - max MEM_WAIT cycles before the sticky fault
//               CNT_W       - width of the optional performance counters
//   Inputs : clk, reset (synchronous, active high), ifIdRs/ifIdRt/ifIdOpCode,
//            idExMemRead/idExRt, exBranchTaken, memReq, memReady
//   Outputs: pcWrite, ifIdWrite, stallSignal, ifIdFlush, idExFlush,
//            exMemHold, memTimeout
//   Build option: define HAZARD_PERF_EN to add the stallCount / flushCount
//   saturating counters and their output ports.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ifIdRs,
  input  logic [REG_W-1:0] ifIdRt,
  input  logic [OP_W-1:0]  ifIdOpCode,
  input  logic             idExMemRead,
  input  logic [REG_W-1:0] idExRt,
  input  logic             exBranchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             stallSignal,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             exMemHold,
  output logic             memTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazard_state_t     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic freeze;

  load_use_detect u_load_use_detect (
    .idExMemRead (idExMemRead),
    .idExRt      (idExRt),
    .ifIdRs      (ifIdRs),
    .ifIdRt      (ifIdRt),
    .ifIdOpCode  (ifIdOpCode),
    .hazard      (load_use)
  );

  assign freeze = memReq && !memReady;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    stallSignal = 1'b0;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    exMemHold   = 1'b0;
    memTimeout  = 1'b0;

    if (reset) begin
      // Hold the front end and bubble ID/EX while the core comes out of reset.
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      stallSignal = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            exMemHold  = 1'b1;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = '0;
          end else if (exBranchTaken) begin
            // ID holds a wrong-path instruction, so its load-use is moot.
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
          end else if (load_use) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            stallSignal = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Branch and load-use sources are frozen; they are seen again in RUN.
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          exMemHold = 1'b1;
          if (memReady) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          exMemHold  = 1'b1;
          memTimeout = 1'b1;
        end
        default: begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pcWrite && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (idExFlush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stallCount = stall_count_q;
  assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Scoreboard bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=2).
//   Each cycle's stimulus pushes its expected output vector; the vector is
//   popped and compared at the falling edge of the same cycle.
//   Output vector: {pcWrite, ifIdWrite, stallSignal, ifIdFlush, idExFlush,
//                   exMemHold, memTimeout}
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifIdRs, ifIdRt, idExRt;
  logic [5:0] ifIdOpCode;
  logic       idExMemRead, exBranchTaken, memReq, memReady;
  logic       pcWrite, ifIdWrite, stallSignal, ifIdFlush, idExFlush;
  logic       exMemHold, memTimeout;
`ifdef HAZARD_PERF_EN
  logic [1:0] stallCount, flushCount;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifIdRs        (ifIdRs),
    .ifIdRt        (ifIdRt),
    .ifIdOpCode    (ifIdOpCode),
    .idExMemRead   (idExMemRead),
    .idExRt        (idExRt),
    .exBranchTaken (exBranchTaken),
    .memReq        (memReq),
    .memReady      (memReady),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .stallSignal   (stallSignal),
    .ifIdFlush     (ifIdFlush),
    .idExFlush     (idExFlush),
    .exMemHold     (exMemHold),
    .memTimeout    (memTimeout)
`ifdef HAZARD_PERF_EN
    ,
    .stallCount    (stallCount),
    .flushCount    (flushCount)
`endif
  );

  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_RST   = 7'b0010000;
  localparam logic [6:0] O_STALL = 7'b0010000;
  localparam logic [6:0] O_FLUSH = 7'b1101100;
  localparam logic [6:0] O_FRZ   = 7'b0000010;
  localparam logic [6:0] O_TMO   = 7'b0000011;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] op;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic [6:0] exp_q[$];
  logic [6:0] obs;
  logic [6:0] exp_v;
  int n_tests = 0;
  int n_fail  = 0;

  assign obs = {pcWrite, ifIdWrite, stallSignal, ifIdFlush, idExFlush,
                exMemHold, memTimeout};

  function automatic vec_t mk(logic rst, logic mr, logic [4:0] exrt,
                              logic [4:0] rs, logic [4:0] rt, logic [5:0] op,
                              logic br, logic req, logic rdy, logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.mr = mr; v.exrt = exrt; v.rs = rs; v.rt = rt; v.op = op;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the rising edge, record its
  // expected outputs, then wait for the falling edge where they are sampled.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset         = v.rst;
    idExMemRead   = v.mr;
    idExRt        = v.exrt;
    ifIdRs        = v.rs;
    ifIdRt        = v.rt;
    ifIdOpCode    = v.op;
    exBranchTaken = v.br;
    memReq        = v.req;
    memReady      = v.rdy;
    exp_q.push_back(v.exp);
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t tbl[$];
    tbl.push_back(mk(1, 1, 5, 5, 0, 0, 1, 1, 0, O_RST));
    tbl.push_back(mk(1, 1, 5, 5, 0, 0, 1, 1, 0, O_RST));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t tbl[$];
    tbl.push_back(mk(0, 1, 5, 5, 0, 0,  0, 0, 0, O_STALL)); // rs match
    tbl.push_back(mk(0, 0, 5, 5, 0, 0,  0, 0, 0, O_RUN));   // bubble cleared lw
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, O_RUN));   // $zero never stalls
    tbl.push_back(mk(0, 1, 5, 3, 5, 35, 0, 0, 0, O_RUN));   // lw does not read rt
    tbl.push_back(mk(0, 1, 5, 3, 5, 43, 0, 0, 0, O_STALL)); // sw reads rt
    tbl.push_back(mk(0, 1, 5, 3, 5, 4,  0, 0, 0, O_STALL)); // beq reads rt
    tbl.push_back(mk(0, 1, 5, 3, 5, 0,  0, 0, 0, O_STALL)); // R-type reads rt
    tbl.push_back(mk(0, 1, 5, 3, 6, 0,  0, 0, 0, O_RUN));   // no match
    tbl.push_back(mk(0, 1, 5, 3, 5, 2,  0, 0, 0, O_RUN));   // j ignores rt
    tbl.push_back(mk(0, 0, 5, 5, 5, 0,  0, 0, 0, O_RUN));   // not a load
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_branch();
    vec_t tbl[$];
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FLUSH));
    tbl.push_back(mk(0, 1, 7, 7, 0, 0, 1, 0, 0, O_FLUSH)); // flush beats load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_mem_wait();
    vec_t tbl[$];
    // Three frozen cycles (detect + two MEM_WAIT) with a pending branch.
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 1, 1, 0, O_FRZ));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 1, 1, 0, O_FRZ));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 1, 1, 1, O_FRZ));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 1, 0, 0, O_FLUSH)); // deferred flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    // Ready in the detect cycle: no freeze, stays in RUN.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, 0, 0, O_STALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mem_wait[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t tbl[$];
    for (int c = 0; c < 5; c++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    for (int c = 0; c < 3; c++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_TMO));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, O_TMO));   // only reset leaves
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    tbl.push_back(mk(0, 1, 4, 4, 0, 0, 0, 0, 0, O_STALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL timeout[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    vec_t tbl[$];
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, O_STALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, O_STALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FLUSH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL perf[%0d] got=%b want=%b", i, obs, exp_v);
      end
    end
    n_tests++;
    if (stallCount !== 2'd2) begin
      n_fail++;
      $display("FAIL stall_count got=%0d want=2", stallCount);
    end
    n_tests++;
    if (flushCount !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_count got=%0d want=1", flushCount);
    end
    for (int s = 0; s < 3; s++) begin
      apply(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, O_STALL));
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL perf_sat[%0d] got=%b want=%b", s, obs, exp_v);
      end
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    exp_v = exp_q.pop_front();
    n_tests++;
    if (stallCount !== 2'd3) begin
      n_fail++;
      $display("FAIL stall_count_sat got=%0d want=3", stallCount);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idExMemRead = 1'b0; idExRt = '0; ifIdRs = '0; ifIdRt = '0;
    ifIdOpCode = '0; exBranchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
